reg_writeback_queue: RTL and testbench



---
 rtl/reg_writeback_queue_if.sv | 54 +++++
 rtl/reg_writeback_queue.sv | 110 +++++++++++
 tb/tb_reg_writeback_queue.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_queue_if.sv
// ----------------------------------------------------------------------------
// reg_writeback_queue_if
//   Bundles every non-clock signal of the register write-back queue.
//   Ports (directions given for the slave, i.e. the queue itself):
//     flush          in   synchronous queue clear
//     wbValid        in   producer has a write request
//     wbReady        out  queue can accept this cycle
//     wbReg/wbData   in   destination register and data of the request
//     drainEnable    in   downstream permits a register-file write
//     rfWrite*       out  register-file writeEnable/writeReg/writeData
//     lookupReg1/2   in   operand read addresses
//     fwdHit1/2      out  a queued entry targets the lookup address
//     fwdData1/2     out  data of the youngest matching entry (0 on miss)
//     pendingCount   out  number of queued entries
//   Handshake: a request transfers on a rising clk edge where wbValid and
//   wbReady are both 1; wbReady never depends on wbValid or drainEnable.
//   A register-file write happens on every rising edge with rfWriteEnable=1.
// ----------------------------------------------------------------------------
interface reg_writeback_queue_if #(
    parameter int n     = 32,
    parameter int r     = 7,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          wbValid;
    logic          wbReady;
    logic [r-1:0]  wbReg;
    logic [n-1:0]  wbData;
    logic          drainEnable;
    logic          rfWriteEnable;
    logic [r-1:0]  rfWriteReg;
    logic [n-1:0]  rfWriteData;
    logic [r-1:0]  lookupReg1;
    logic [r-1:0]  lookupReg2;
    logic          fwdHit1;
    logic [n-1:0]  fwdData1;
    logic          fwdHit2;
    logic [n-1:0]  fwdData2;
    logic [CW-1:0] pendingCount;

    modport slave (
        input  flush, wbValid, wbReg, wbData, drainEnable, lookupReg1, lookupReg2,
        output wbReady, rfWriteEnable, rfWriteReg, rfWriteData,
               fwdHit1, fwdData1, fwdHit2, fwdData2, pendingCount
    );

    modport master (
        output flush, wbValid, wbReg, wbData, drainEnable, lookupReg1, lookupReg2,
        input  wbReady, rfWriteEnable, rfWriteReg, rfWriteData,
               fwdHit1, fwdData1, fwdHit2, fwdData2, pendingCount
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// ----------------------------------------------------------------------------
// reg_writeback_queue
//   In-order write-back buffer in front of the register-file write port.
//   Accepts one {reg, data} request per cycle, drains one entry per cycle
//   into the register file, and forwards still-queued data to two operand
//   lookups so reads never see stale values.
//   Ports:
//     clk     rising-edge clock
//     nReset  asynchronous active-low reset (discards all pending writes)
//     bus     reg_writeback_queue_if.slave, see the interface for signals
// ----------------------------------------------------------------------------
module reg_writeback_queue #(
    parameter int n     = 32,
    parameter int r     = 7,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   nReset,
    reg_writeback_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage carries no reset: only head..head+count-1 is ever read.
    logic [r-1:0]  reg_mem_q  [DEPTH];
    logic [n-1:0]  data_mem_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic accept;
    logic drain;

    // Ready looks only at registered state and flush, so a full queue
    // refuses even on a cycle where it is also draining.
    assign bus.wbReady       = (count_q < CW'(DEPTH)) && !bus.flush;
    assign bus.rfWriteEnable = (count_q != '0) && bus.drainEnable && !bus.flush;
    assign bus.rfWriteReg    = reg_mem_q[head_q];
    assign bus.rfWriteData   = data_mem_q[head_q];
    assign bus.pendingCount  = count_q;

    assign accept = bus.wbValid && bus.wbReady;
    assign drain  = bus.rfWriteEnable;

    // Pointer/count next state. Flush wins; accept and drain are already
    // suppressed by flush through wbReady/rfWriteEnable.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (accept) tail_d = tail_q + PW'(1);
            if (drain)  head_d = head_q + PW'(1);
            case ({accept, drain})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            reg_mem_q[tail_q]  <= bus.wbReg;
            data_mem_q[tail_q] <= bus.wbData;
        end
    end

    // Forwarding: walk from oldest to youngest valid entry; a later match
    // overwrites an earlier one, leaving the youngest. The head being
    // drained this cycle is still included.
    always_comb begin
        logic [PW-1:0] idx;
        bus.fwdHit1  = 1'b0;
        bus.fwdData1 = '0;
        bus.fwdHit2  = 1'b0;
        bus.fwdData2 = '0;
        idx          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (reg_mem_q[idx] == bus.lookupReg1) begin
                    bus.fwdHit1  = 1'b1;
                    bus.fwdData1 = data_mem_q[idx];
                end
                if (reg_mem_q[idx] == bus.lookupReg2) begin
                    bus.fwdHit2  = 1'b1;
                    bus.fwdData2 = data_mem_q[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback_queue.sv
module tb_reg_writeback_queue;
    localparam int N     = 32;
    localparam int R     = 7;
    localparam int DEPTH = 4;
    localparam int E     = R + N;

    // ---------------- clock / reset ----------------
    logic clk;
    logic nReset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_writeback_queue_if #(.n(N), .r(R), .DEPTH(DEPTH)) bus ();

    reg_writeback_queue #(.n(N), .r(R), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    // ---------------- scoreboard ----------------
    // Reference queue of pending writes, oldest at index 0: {reg, data}.
    logic [E-1:0] exp_q[$];
    int checks;
    int errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Youngest pending entry whose reg matches; data 0 on miss.
    task automatic model_fwd(input logic [R-1:0] lk, output logic hit, output logic [N-1:0] dat);
        hit = 1'b0;
        dat = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i][E-1:N] == lk) begin
                hit = 1'b1;
                dat = exp_q[i][N-1:0];
                break;
            end
        end
    endtask

    // Compare all outputs against the model for the current inputs.
    task automatic check_outputs();
        logic          h;
        logic [N-1:0]  d;
        logic          exp_ready;
        logic          exp_we;
        exp_ready = (exp_q.size() < DEPTH) && !bus.flush;
        exp_we    = (exp_q.size() != 0) && bus.drainEnable && !bus.flush;
        check("wbReady", 64'(bus.wbReady), 64'(exp_ready));
        check("rfWriteEnable", 64'(bus.rfWriteEnable), 64'(exp_we));
        check("pendingCount", 64'(bus.pendingCount), 64'(exp_q.size()));
        if (exp_q.size() != 0) begin
            check("rfWriteReg", 64'(bus.rfWriteReg), 64'(exp_q[0][E-1:N]));
            check("rfWriteData", 64'(bus.rfWriteData), 64'(exp_q[0][N-1:0]));
        end
        model_fwd(bus.lookupReg1, h, d);
        check("fwdHit1", 64'(bus.fwdHit1), 64'(h));
        check("fwdData1", 64'(bus.fwdData1), 64'(d));
        model_fwd(bus.lookupReg2, h, d);
        check("fwdHit2", 64'(bus.fwdHit2), 64'(h));
        check("fwdData2", 64'(bus.fwdData2), 64'(d));
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge: drive, check, cross the rising edge,
    // apply the model, return at the next falling edge.
    task automatic step(input logic v, input logic [R-1:0] rg, input logic [N-1:0] dt,
                        input logic dr, input logic fl,
                        input logic [R-1:0] l1, input logic [R-1:0] l2);
        logic acc;
        logic drn;
        bus.wbValid     = v;
        bus.wbReg       = rg;
        bus.wbData      = dt;
        bus.drainEnable = dr;
        bus.flush       = fl;
        bus.lookupReg1  = l1;
        bus.lookupReg2  = l2;
        #1;
        check_outputs();
        acc = v && (exp_q.size() < DEPTH) && !fl;
        drn = dr && (exp_q.size() != 0) && !fl;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({rg, dt});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic dr);
        step(1'b0, '0, '0, dr, 1'b0, '0, '0);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 8; i++) idle(1'b1);
        check("drained_empty", 64'(bus.pendingCount), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        nReset          = 1'b0;
        bus.flush       = 1'b0;
        bus.wbValid     = 1'b0;
        bus.wbReg       = '0;
        bus.wbData      = '0;
        bus.drainEnable = 1'b1;
        bus.lookupReg1  = '0;
        bus.lookupReg2  = '0;
        #1;
        check("rst_pending", 64'(bus.pendingCount), 64'd0);
        check("rst_ready", 64'(bus.wbReady), 64'd1);
        check("rst_we", 64'(bus.rfWriteEnable), 64'd0);
        check("rst_hit1", 64'(bus.fwdHit1), 64'd0);
        check("rst_hit2", 64'(bus.fwdHit2), 64'd0);
        @(negedge clk);
        nReset = 1'b1;

        // Reset mid-operation with 3 entries queued.
        step(1'b1, 7'd3, 32'h33, 1'b0, 1'b0, '0, '0);
        step(1'b1, 7'd4, 32'h44, 1'b0, 1'b0, '0, '0);
        step(1'b1, 7'd6, 32'h66, 1'b0, 1'b0, 7'd3, 7'd6);
        check("pre_rst_count", 64'(bus.pendingCount), 64'd3);
        bus.wbValid     = 1'b0;
        bus.drainEnable = 1'b1;
        bus.lookupReg1  = 7'd3;
        bus.lookupReg2  = 7'd6;
        #2;
        nReset = 1'b0;
        #1;
        check("async_rst_pending", 64'(bus.pendingCount), 64'd0);
        check("async_rst_we", 64'(bus.rfWriteEnable), 64'd0);
        check("async_rst_ready", 64'(bus.wbReady), 64'd1);
        check("async_rst_hit1", 64'(bus.fwdHit1), 64'd0);
        check("async_rst_hit2", 64'(bus.fwdHit2), 64'd0);
        exp_q.delete();
        @(negedge clk);
        nReset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 7'd3, 7'd6);

        // Single write, drainEnable=1.
        step(1'b1, 7'd5, 32'hDEADBEEF, 1'b1, 1'b0, '0, '0);
        bus.wbValid = 1'b0;
        #1;
        check("single_we", 64'(bus.rfWriteEnable), 64'd1);
        check("single_reg", 64'(bus.rfWriteReg), 64'd5);
        check("single_data", 64'(bus.rfWriteData), 64'hDEADBEEF);
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        check("single_after", 64'(bus.pendingCount), 64'd0);

        // Fill and stall: offer regs 1..5 with drain off.
        for (int i = 1; i <= 5; i++)
            step(1'b1, R'(i), N'(32'h100 + i), 1'b0, 1'b0, '0, '0);
        check("full_count", 64'(bus.pendingCount), 64'd4);
        check("full_ready", 64'(bus.wbReady), 64'd0);
        // Keep offering reg 5 while draining; model decides when it lands.
        for (int i = 0; i < 3; i++)
            step(1'b1, 7'd5, 32'h105, 1'b1, 1'b0, '0, '0);
        drain_all();

        // Wrap-around with concurrent enqueue/drain.
        for (int i = 10; i <= 19; i++)
            step(1'b1, R'(i), N'(32'hA000 + i), 1'b1, 1'b0, 7'd15, 7'd19);
        check("wrap_count", 64'(bus.pendingCount), 64'd1);
        drain_all();

        // Forwarding youngest.
        step(1'b1, 7'd7, 32'h1, 1'b0, 1'b0, 7'd7, 7'd8);
        step(1'b1, 7'd7, 32'h2, 1'b0, 1'b0, 7'd7, 7'd8);
        step(1'b1, 7'd9, 32'h3, 1'b0, 1'b0, 7'd7, 7'd8);
        bus.wbValid = 1'b0;
        #1;
        check("fwd_hit1", 64'(bus.fwdHit1), 64'd1);
        check("fwd_data1", 64'(bus.fwdData1), 64'h2);
        check("fwd_hit2", 64'(bus.fwdHit2), 64'd0);
        check("fwd_data2", 64'(bus.fwdData2), 64'h0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 7'd7, 7'd8);
        check("fwd_after_drain", 64'(bus.fwdData1), 64'h2);
        drain_all();

        // Flush priority over accept and drain.
        step(1'b1, 7'd20, 32'hF0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 7'd21, 32'hF1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 7'd22, 32'hF2, 1'b0, 1'b0, '0, '0);
        step(1'b1, 7'd23, 32'hF3, 1'b1, 1'b1, 7'd20, 7'd23);
        check("flush_count", 64'(bus.pendingCount), 64'd0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Randomized traffic over a small register range to provoke hits.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 R'($urandom_range(0, 7)), N'($urandom),
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                 R'($urandom_range(0, 7)), R'($urandom_range(0, 7)));
        end
        drain_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
